dff_sync_reset: RTL and testbench



---
 rtl/dff_pkg.sv | 14 +
 rtl/dff_sync_reset_stage.sv | 30 +++
 rtl/dff_sync_reset.sv | 67 ++++++
 tb/tb_dff_sync_reset.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/dff_pkg.sv
// ============================================================================
// dff_pkg : shared defaults for the dff_sync_reset register family
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package dff_pkg;

  localparam int DFF_DEFAULT_WIDTH  = 1;
  localparam int DFF_DEFAULT_STAGES = 1;

endpackage : dff_pkg

`default_nettype wire

// File: rtl/dff_sync_reset_stage.sv
// ============================================================================
// dff_sync_reset_stage : one WIDTH-wide register with synchronous reset
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module dff_sync_reset_stage
  import dff_pkg::*;
#(
  parameter int                 WIDTH       = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // q comes straight off the flops so it never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule : dff_sync_reset_stage

`default_nettype wire

// File: rtl/dff_sync_reset.sv
// ============================================================================
// dff_sync_reset : STAGES-deep register chain with synchronous active-high reset
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module dff_sync_reset
  import dff_pkg::*;
#(
  parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               STAGES      = DFF_DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (WIDTH < 1 || STAGES < 1) begin : g_param_check
      $fatal(1, "dff_sync_reset: WIDTH and STAGES must both be >= 1");
    end
  endgenerate

  // w_chain[0] is the input; w_chain[i+1] is the output of stage i.
  logic [WIDTH-1:0] w_chain [STAGES+1];

  assign w_chain[0] = d;

  generate
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      dff_sync_reset_stage #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
      ) u_stage (
        .clk   (clk),
        .reset (reset),
        .d     (w_chain[i]),
        .q     (w_chain[i+1])
      );
    end
  endgenerate

  assign q = w_chain[STAGES];

`ifndef SYNTHESIS
  logic r_reset_seen;

  always_ff @(posedge clk) begin
    r_reset_seen <= reset;
  end

  // Values read here are the pre-edge ones: q reflects the previous edge.
  always @(posedge clk) begin
    assert (!$isunknown(reset))
      else $error("dff_sync_reset: reset is X/Z at rising clk");
    if (r_reset_seen) begin
      assert (q == RESET_VALUE)
        else $error("dff_sync_reset: q != RESET_VALUE one edge after reset");
    end
  end
`endif

endmodule : dff_sync_reset

`default_nettype wire

// File: tb/tb_dff_sync_reset.sv
// ============================================================================
// tb_dff_sync_reset : self-checking bench for dff_sync_reset (two configurations)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_dff_sync_reset;

  localparam logic [7:0] RV_B     = 8'hA5;
  localparam int         STAGES_B = 3;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [0:0] d_a, q_a;
  logic [7:0] d_b, q_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dff_sync_reset #(.WIDTH(1), .RESET_VALUE(1'b0), .STAGES(1)) u_a (
    .clk(clk), .reset(rst_a), .d(d_a), .q(q_a)
  );

  dff_sync_reset #(.WIDTH(8), .RESET_VALUE(RV_B), .STAGES(STAGES_B)) u_b (
    .clk(clk), .reset(rst_b), .d(d_b), .q(q_b)
  );

  typedef struct {
    logic       r;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic       r;
    logic [7:0] d;
  } hist_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Output after an edge equals the oldest input in the latency window,
  // unless any edge in that window sampled reset.
  function automatic logic [7:0] model(input hist_t h[$], input logic [7:0] rv);
    logic any_reset = 1'b0;
    foreach (h[i]) any_reset |= h[i].r;
    return any_reset ? rv : h[0].d;
  endfunction

  task automatic edge_and_settle();
    @(posedge clk);
    #1;
  endtask

  vec_t  va[$];
  vec_t  vb[$];
  hist_t ha[$];
  hist_t hb[$];

  initial begin
    int unused_seed;
    rst_a = 1'b1; d_a = 1'b0;
    rst_b = 1'b1; d_b = 8'h00;

    // WIDTH=1 basics plus reset-vs-data priority
    va = '{
      '{1'b1, 8'h01, 8'h00},
      '{1'b0, 8'h01, 8'h01},
      '{1'b0, 8'h00, 8'h00},
      '{1'b0, 8'h01, 8'h01},
      '{1'b1, 8'h01, 8'h00},
      '{1'b0, 8'h01, 8'h01},
      '{1'b0, 8'h00, 8'h00}
    };
    // 3-stage pipeline fill, then reset mid-stream discarding 04/05
    vb = '{
      '{1'b1, 8'h00, RV_B},
      '{1'b0, 8'h01, RV_B},
      '{1'b0, 8'h02, RV_B},
      '{1'b0, 8'h03, 8'h01},
      '{1'b0, 8'h04, 8'h02},
      '{1'b0, 8'h05, 8'h03},
      '{1'b1, 8'h06, RV_B},
      '{1'b0, 8'h07, RV_B},
      '{1'b0, 8'h08, RV_B},
      '{1'b0, 8'h09, 8'h07},
      '{1'b0, 8'h0A, 8'h08}
    };

    @(negedge clk);
    for (int i = 0; i < vb.size(); i++) begin
      if (i < va.size()) begin
        rst_a = va[i].r; d_a = va[i].d[0];
      end
      rst_b = vb[i].r; d_b = vb[i].d;
      edge_and_settle();
      if (i < va.size()) check($sformatf("vec_a[%0d]", i), {7'd0, q_a}, va[i].exp);
      check($sformatf("vec_b[%0d]", i), q_b, vb[i].exp);
      @(negedge clk);
    end

    // Synchronicity: reset raised between edges does nothing until sampled.
    rst_a = 1'b0; d_a = 1'b1;
    edge_and_settle();
    check("sync_pre", {7'd0, q_a}, 8'h01);
    @(negedge clk);
    rst_a = 1'b1;
    #2;
    check("sync_midcycle_hold", {7'd0, q_a}, 8'h01);
    edge_and_settle();
    check("sync_reset_edge", {7'd0, q_a}, 8'h00);

    // Hold: toggling d without a clock edge leaves q unchanged.
    @(negedge clk);
    rst_a = 1'b0; d_a = 1'b1;
    edge_and_settle();
    check("hold_start", {7'd0, q_a}, 8'h01);
    @(negedge clk);
    d_a = 1'b0; #1; check("hold_d0", {7'd0, q_a}, 8'h01);
    d_a = 1'b1; #1; check("hold_d1", {7'd0, q_a}, 8'h01);
    d_a = 1'b0; #1; check("hold_d0b", {7'd0, q_a}, 8'h01);
    d_a = 1'b1;

    // Randomized run on both instances against the window model.
    unused_seed = $urandom(32'd20240611);
    @(negedge clk);
    for (int n = 0; n < 60; n++) begin
      hist_t ea, eb;
      ea.r = ($urandom_range(0, 5) == 0);
      ea.d = {7'd0, 1'($urandom_range(0, 1))};
      eb.r = ($urandom_range(0, 6) == 0);
      eb.d = 8'($urandom_range(0, 255));
      rst_a = ea.r; d_a = ea.d[0];
      rst_b = eb.r; d_b = eb.d;
      edge_and_settle();
      ha.push_back(ea);
      if (ha.size() > 1) void'(ha.pop_front());
      hb.push_back(eb);
      if (hb.size() > STAGES_B) void'(hb.pop_front());
      check($sformatf("rand_a[%0d]", n), {7'd0, q_a}, model(ha, 8'h00));
      if (hb.size() == STAGES_B)
        check($sformatf("rand_b[%0d]", n), q_b, model(hb, RV_B));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dff_sync_reset

`default_nettype wire
